sprite_datapath: RTL and testbench
==================================

# sprite_datapath

Datapath stage driven directly by the game control FSM. It consumes `datapath_en`, `op`, `move_en` and `load_coord`, and returns `done` and `touch_edge` to the FSM. It holds the sprite position and direction, and sweeps a SPRITE_W×SPRITE_W pixel block to the VGA adapter's plot port, using the sprite colour for draw or background for erase. It also advances the position one step per `load_coord`.

## Interface
- SPRITE_W, 4: sprite edge length in pixels; must be a power of two, ≤ 8.
- SCREEN_W, 160: screen width in pixels.
- SCREEN_H, 120: screen height in pixels.
- X_INIT, 0: reset x position (top-left corner).
- Y_INIT, 0: reset y position (top-left corner).
- COLOUR, 3'b111: draw colour; erase colour is 3'b000.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  asynchronous, active-high reset.
- datapath_en  in  1  request a pixel sweep.
- op  in  2  00 = draw, 01 = erase, 10/11 = sweep with plot held 0.
- move_en  in  1  qualifies `load_coord`.
- load_coord  in  1  advance position one step.
- x_out  out  8  pixel x.
- y_out  out  7  pixel y.
- colour  out  3  pixel colour.
- plot  out  1  pixel write strobe.
- done  out  1  one-cycle pulse on the last pixel of a sweep.
- touch_edge  out  1  sprite occupies the bottom row band.

## Operation
- States: IDLE, SWEEP, FINISH.
  - IDLE→SWEEP when `datapath_en`=1; `op` is latched at this transition.
  - SWEEP→FINISH after pixel N²−1 (N = SPRITE_W).
  - FINISH→IDLE when `datapath_en`=0.
  - SWEEP→IDLE at once if `datapath_en` drops mid-sweep; counter clears, `done` is not pulsed.
- Pixel counter `cnt`, log2(N²) bits:
  - `x_out` = x_pos + cnt[low half]; `y_out` = y_pos + cnt[high half].
  - Row-major order: pixel i = (i mod N, i div N).
- Colour/plot per latched op: 00 → COLOUR with plot=1; 01 → 3'b000 with plot=1; other → plot=0, timing unchanged.
- Position update:
  - Honoured only when `load_coord`=1, `move_en`=1 and state=IDLE; ignored otherwise.
  - x_pos += dx and y_pos += dy, with dx, dy ∈ {+1, −1}.
  - Reset: dx=+1, dy=+1.
- Edge handling: with the macro defined, see Configuration. Without it:
  - x wraps SCREEN_W−N → 0 and 0 → SCREEN_W−N; y wraps the same way on SCREEN_H−N.
  - Direction never changes.
- touch_edge: registered, =1 whenever y_pos == SCREEN_H−N, evaluated after each update.
- Reset values: x_pos=X_INIT, y_pos=Y_INIT, state=IDLE, cnt=0, x_out=0, y_out=0, colour=0, plot=0, done=0, touch_edge=0.
- Reset mid-sweep: all outputs return to their reset values immediately (asynchronous).

## Timing
- Outputs are registered.
- `datapath_en` is sampled high in IDLE at cycle k. Pixel i is presented at cycle k+1+i with plot=1.
- `done`=1 only at cycle k+N², coincident with the last pixel; the sweep is N² cycles long (16 at default).
- In FINISH: plot=0 and done=0, even if `datapath_en` stays high. No restart until `datapath_en` has been low for ≥1 cycle.
- `load_coord` sampled at cycle k: the new x_pos/y_pos and touch_edge are visible at k+1.
- `load_coord` and `datapath_en` both high in IDLE: the position update applies first. The sweep starting at k+1 uses the new position.

## Configuration
- SPRITE_DATAPATH_BOUNCE_EN defined (bounce):
  - Reflect at the edges. If dx=+1 and x_pos == SCREEN_W−N, then dx becomes −1 and x_pos becomes x_pos−1 in the same update.
  - Symmetric at 0 and for y.
- SPRITE_DATAPATH_BOUNCE_EN undefined: wrap-around as described in Operation.

## Structure
- Package `sprite_pkg`:
  - Op codes: OP_DRAW=2'b00, OP_ERASE=2'b01.
  - State enum: IDLE, SWEEP, FINISH.
  - Default screen constants, and the erase colour 3'b000.
- One sub-module, `pixel_sweep_counter`:
  - Inputs: clear, enable.
  - Outputs: cnt, last (cnt == N²−1).
  - Instantiated once.
- Position/direction registers and the FSM stay in `sprite_datapath`.

## Test plan
- Reset, then `datapath_en`=1 with op=00 at cycle 0 → 16 plots at (0,0)…(3,3) in row-major order, colour 3'b111, over cycles 1–16; done=1 only at cycle 16.
- op=01 sweep at (10,20) → 16 plots with colour 0, covering x 10–13, y 20–23.
- `datapath_en` dropped at sweep cycle 5 → plot=0 next cycle, no done pulse; the next sweep restarts at pixel 0.
- Bounce build, x_pos=156, dx=+1, `load_coord` with `move_en`=1 → x_pos=155, dx=−1. Wrap build, same stimulus → x_pos=0.
- y_pos=115, dy=+1, `load_coord` → y_pos=116 and touch_edge=1 the next cycle. `load_coord` during SWEEP → position unchanged.
- `datapath_en` held high through FINISH → no second sweep and no second done pulse.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared op codes, FSM state encoding and screen defaults for the sprite datapath.
package sprite_pkg;

  localparam logic [1:0] OP_DRAW  = 2'b00;
  localparam logic [1:0] OP_ERASE = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWEEP  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int SPRITE_W_DEF = 4;
  localparam int SCREEN_W_DEF = 160;
  localparam int SCREEN_H_DEF = 120;

  localparam logic [2:0] DRAW_COLOUR_DEF = 3'b111;
  localparam logic [2:0] ERASE_COLOUR    = 3'b000;

  function automatic logic op_plots(input logic [1:0] op);
    return (op == OP_DRAW) || (op == OP_ERASE);
  endfunction

endpackage

// File: rtl/sprite_datapath_if.sv
// Control/plot bundle between the game FSM (master) and the sprite datapath (slave).
interface sprite_datapath_if;
  logic       datapath_en;
  logic [1:0] op;
  logic       move_en;
  logic       load_coord;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       done;
  logic       touch_edge;

  modport master (
    output datapath_en, op, move_en, load_coord,
    input  x_out, y_out, colour, plot, done, touch_edge
  );

  modport slave (
    input  datapath_en, op, move_en, load_coord,
    output x_out, y_out, colour, plot, done, touch_edge
  );
endinterface

// File: rtl/sprite_datapath_pixel_sweep_counter.sv
// Row-major pixel index for one SPRITE_W x SPRITE_W sweep; low half is column, high half row.
module pixel_sweep_counter #(
  parameter  int SPRITE_W = 4,
  localparam int CW       = 2 * $clog2(SPRITE_W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] cnt,
  output logic          last
);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (clear)
      r_cnt <= '0;
    else if (enable)
      r_cnt <= r_cnt + CW'(1);
  end

  assign cnt  = r_cnt;
  assign last = (r_cnt == CW'(SPRITE_W * SPRITE_W - 1));

endmodule

// File: rtl/sprite_datapath.sv
// Sprite position/direction holder and pixel sweeper; edge bounce when SPRITE_DATAPATH_BOUNCE_EN is defined, wrap otherwise.
// state  | meaning
// IDLE   | waiting for datapath_en; position moves allowed
// SWEEP  | presenting pixels 1..N^2-1 (pixel 0 leaves IDLE)
// FINISH | sweep complete; waits for datapath_en low
module sprite_datapath
  import sprite_pkg::*;
#(
  parameter int         SPRITE_W = SPRITE_W_DEF,
  parameter int         SCREEN_W = SCREEN_W_DEF,
  parameter int         SCREEN_H = SCREEN_H_DEF,
  parameter int         X_INIT   = 0,
  parameter int         Y_INIT   = 0,
  parameter logic [2:0] COLOUR   = DRAW_COLOUR_DEF
) (
  input logic              clk,
  input logic              reset,
  sprite_datapath_if.slave bus
);

  localparam int         LW    = $clog2(SPRITE_W);
  localparam int         CW    = 2 * LW;
  localparam logic [7:0] X_MAX = 8'(SCREEN_W - SPRITE_W);
  localparam logic [6:0] Y_MAX = 7'(SCREEN_H - SPRITE_W);

  state_t r_state, w_state_next;

  logic [1:0]    r_op, w_op_eff;
  logic [CW-1:0] w_cnt;
  logic          w_last;
  logic          w_fire, w_cnt_en, w_cnt_clr, w_done, w_latch_op;

  logic [7:0] r_x_pos, w_x_next, w_x_eff;
  logic [6:0] r_y_pos, w_y_next, w_y_eff;
  logic       r_dx_neg, r_dy_neg, w_dx_neg_next, w_dy_neg_next;
  logic       w_move;

  logic [7:0] r_x_out;
  logic [6:0] r_y_out;
  logic [2:0] r_colour;
  logic       r_plot, r_done, r_touch;

  pixel_sweep_counter #(.SPRITE_W(SPRITE_W)) u_cnt (
    .clk    (clk),
    .rst    (reset),
    .clear  (w_cnt_clr),
    .enable (w_cnt_en),
    .cnt    (w_cnt),
    .last   (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_fire       = 1'b0;
    w_cnt_en     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_done       = 1'b0;
    w_latch_op   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.datapath_en) begin
          w_state_next = SWEEP;
          w_fire       = 1'b1;
          w_cnt_en     = 1'b1;
          w_latch_op   = 1'b1;
        end
      end
      SWEEP: begin
        if (!bus.datapath_en) begin
          w_state_next = IDLE;
          w_cnt_clr    = 1'b1;
        end else begin
          w_fire = 1'b1;
          if (w_last) begin
            w_done       = 1'b1;
            w_cnt_clr    = 1'b1;
            w_state_next = FINISH;
          end else begin
            w_cnt_en = 1'b1;
          end
        end
      end
      FINISH: begin
        if (!bus.datapath_en)
          w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_move = bus.load_coord && bus.move_en && (r_state == IDLE);

  always_comb begin
    w_dx_neg_next = r_dx_neg;
    w_dy_neg_next = r_dy_neg;
    w_x_next      = r_x_pos;
    w_y_next      = r_y_pos;
`ifdef SPRITE_DATAPATH_BOUNCE_EN
    // Reflection and the step away from the edge happen in the same update.
    if (!r_dx_neg && r_x_pos == X_MAX)
      w_dx_neg_next = 1'b1;
    else if (r_dx_neg && r_x_pos == '0)
      w_dx_neg_next = 1'b0;
    if (!r_dy_neg && r_y_pos == Y_MAX)
      w_dy_neg_next = 1'b1;
    else if (r_dy_neg && r_y_pos == '0)
      w_dy_neg_next = 1'b0;
    w_x_next = w_dx_neg_next ? r_x_pos - 8'd1 : r_x_pos + 8'd1;
    w_y_next = w_dy_neg_next ? r_y_pos - 7'd1 : r_y_pos + 7'd1;
`else
    if (r_dx_neg)
      w_x_next = (r_x_pos == '0) ? X_MAX : r_x_pos - 8'd1;
    else
      w_x_next = (r_x_pos == X_MAX) ? '0 : r_x_pos + 8'd1;
    if (r_dy_neg)
      w_y_next = (r_y_pos == '0) ? Y_MAX : r_y_pos - 7'd1;
    else
      w_y_next = (r_y_pos == Y_MAX) ? '0 : r_y_pos + 7'd1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x_pos  <= 8'(X_INIT);
      r_y_pos  <= 7'(Y_INIT);
      r_dx_neg <= 1'b0;
      r_dy_neg <= 1'b0;
      r_touch  <= 1'b0;
    end else if (w_move) begin
      r_x_pos  <= w_x_next;
      r_y_pos  <= w_y_next;
      r_dx_neg <= w_dx_neg_next;
      r_dy_neg <= w_dy_neg_next;
      r_touch  <= (w_y_next == Y_MAX);
    end
  end

  // Pixel 0 leaves IDLE, so it must see a same-cycle move and the incoming op.
  assign w_x_eff  = w_move ? w_x_next : r_x_pos;
  assign w_y_eff  = w_move ? w_y_next : r_y_pos;
  assign w_op_eff = (r_state == IDLE) ? bus.op : r_op;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_op <= OP_DRAW;
    else if (w_latch_op)
      r_op <= bus.op;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x_out  <= '0;
      r_y_out  <= '0;
      r_colour <= '0;
      r_plot   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_done;
      if (w_fire) begin
        r_x_out  <= w_x_eff + 8'(w_cnt[LW-1:0]);
        r_y_out  <= w_y_eff + 7'(w_cnt[CW-1:LW]);
        r_plot   <= op_plots(w_op_eff);
        r_colour <= (w_op_eff == OP_DRAW) ? COLOUR : ERASE_COLOUR;
      end else begin
        r_plot <= 1'b0;
      end
    end
  end

  assign bus.x_out      = r_x_out;
  assign bus.y_out      = r_y_out;
  assign bus.colour     = r_colour;
  assign bus.plot       = r_plot;
  assign bus.done       = r_done;
  assign bus.touch_edge = r_touch;

endmodule

// File: tb/tb_sprite_datapath.sv
// Directed + randomized bench for sprite_datapath against a position/sweep model.
module tb_sprite_datapath;

  localparam int N    = 4;
  localparam int NN   = N * N;
  localparam int XMAX = 160 - N;
  localparam int YMAX = 120 - N;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  int mx, my, mdx, mdy;
  bit mtouch;

  sprite_datapath_if bus ();

  sprite_datapath dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    mx = 0; my = 0; mdx = 1; mdy = 1; mtouch = 1'b0;
  endfunction

  function automatic void model_move();
`ifdef SPRITE_DATAPATH_BOUNCE_EN
    if (mx + mdx > XMAX || mx + mdx < 0) mdx = -mdx;
    if (my + mdy > YMAX || my + mdy < 0) mdy = -mdy;
    mx = mx + mdx;
    my = my + mdy;
`else
    mx = mx + mdx;
    my = my + mdy;
    if (mx > XMAX) mx = 0;
    if (mx < 0)    mx = XMAX;
    if (my > YMAX) my = 0;
    if (my < 0)    my = YMAX;
`endif
    mtouch = (my == YMAX);
  endfunction

  task automatic move(input bit me);
    bus.load_coord = 1'b1;
    bus.move_en    = me;
    @(posedge clk); #1;
    if (me) model_move();
    chk("touch_edge", 32'(bus.touch_edge), 32'(mtouch));
    bus.load_coord = 1'b0;
    bus.move_en    = 1'b0;
  endtask

  // abort_after < 0 means run the full sweep and then hold datapath_en through FINISH.
  task automatic sweep(input logic [1:0] o, input int abort_after, input bit with_move);
    bit plots;
    plots = (o == 2'b00) || (o == 2'b01);
    bus.datapath_en = 1'b1;
    bus.op          = o;
    if (with_move) begin
      bus.load_coord = 1'b1;
      bus.move_en    = 1'b1;
      model_move();
    end
    for (int i = 0; i < NN; i++) begin
      @(posedge clk); #1;
      bus.op         = 2'($urandom);
      bus.load_coord = 1'($urandom_range(0, 1));
      bus.move_en    = 1'b1;
      chk("plot", 32'(bus.plot), 32'(plots));
      if (plots) begin
        chk("x_out", 32'(bus.x_out), 32'(mx + i % N));
        chk("y_out", 32'(bus.y_out), 32'(my + i / N));
        chk("colour", 32'(bus.colour), (o == 2'b00) ? 32'd7 : 32'd0);
      end
      chk("done", 32'(bus.done), 32'(i == NN - 1));
      if (i == 0) chk("touch_sweep", 32'(bus.touch_edge), 32'(mtouch));
      if (i == abort_after) begin
        bus.datapath_en = 1'b0;
        @(posedge clk); #1;
        chk("abort_plot", 32'(bus.plot), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        bus.load_coord = 1'b0;
        bus.move_en    = 1'b0;
        return;
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
      chk("finish_plot", 32'(bus.plot), 32'd0);
      chk("finish_done", 32'(bus.done), 32'd0);
    end
    bus.datapath_en = 1'b0;
    @(posedge clk); #1;
    chk("idle_plot", 32'(bus.plot), 32'd0);
    chk("touch_after", 32'(bus.touch_edge), 32'(mtouch));
    bus.load_coord = 1'b0;
    bus.move_en    = 1'b0;
  endtask

  initial begin
    int guard;
    reset           = 1'b1;
    bus.datapath_en = 1'b0;
    bus.op          = 2'b00;
    bus.move_en     = 1'b0;
    bus.load_coord  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk); #1;
    chk("rst_x", 32'(bus.x_out), 32'd0);
    chk("rst_y", 32'(bus.y_out), 32'd0);
    chk("rst_colour", 32'(bus.colour), 32'd0);
    chk("rst_plot", 32'(bus.plot), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_touch", 32'(bus.touch_edge), 32'd0);
    reset = 1'b0;

    sweep(2'b00, -1, 1'b0);
    sweep(2'b01, -1, 1'b0);
    sweep(2'b10, -1, 1'b0);
    sweep(2'b00, 5, 1'b0);
    sweep(2'b00, -1, 1'b0);
    move(1'b0);
    move(1'b1);
    sweep(2'b01, -1, 1'b1);

    for (int it = 0; it < 24; it++) begin
      int nmoves;
      nmoves = $urandom_range(0, 30);
      for (int m = 0; m < nmoves; m++) move(1'($urandom_range(0, 1)));
      sweep(2'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, NN - 2) : -1,
            1'($urandom_range(0, 1)));
    end

    guard = 0;
    while (!(mx == XMAX && mdx == 1) && guard < 2000) begin
      move(1'b1);
      guard++;
    end
    move(1'b1);
    sweep(2'b00, -1, 1'b0);

    guard = 0;
    while (!(my == YMAX - 1 && mdy == 1) && guard < 2000) begin
      move(1'b1);
      guard++;
    end
    move(1'b1);
    chk("touch_band", 32'(bus.touch_edge), 32'(my == YMAX));
    sweep(2'b01, -1, 1'b0);

    bus.datapath_en = 1'b1;
    bus.op          = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_plot", 32'(bus.plot), 32'd0);
    chk("arst_x", 32'(bus.x_out), 32'd0);
    chk("arst_y", 32'(bus.y_out), 32'd0);
    chk("arst_colour", 32'(bus.colour), 32'd0);
    chk("arst_done", 32'(bus.done), 32'd0);
    chk("arst_touch", 32'(bus.touch_edge), 32'd0);
    bus.datapath_en = 1'b0;
    #2;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
    sweep(2'b00, -1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
